// File: rtl/add_seq_pkg.sv
// Shared types and sizing helpers for the multi-word add sequencer.
package add_seq_pkg;

    localparam int unsigned WIDTH_DEF  = 8;
    localparam int unsigned WORDS_DEF  = 4;
    localparam int unsigned SETTLE_DEF = 42;

    localparam int unsigned IDX_W = $clog2(WORDS_DEF);
    localparam int unsigned CNT_W = $clog2(SETTLE_DEF + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        DONE
    } state_t;

    // Register width able to hold values 0..n-1, never narrower than one bit.
    function automatic int unsigned bits_for(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/add_seq_if.sv
// Controller-side handshake and operand/result bus of the add sequencer.
// The sub signal exists only when SUB_MODE_EN is defined.
interface add_seq_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned WORDS = 4
);
    logic                     start;
    logic [WIDTH*WORDS-1:0]   a_in;
    logic [WIDTH*WORDS-1:0]   b_in;
`ifdef SUB_MODE_EN
    logic                     sub;
`endif
    logic                     busy;
    logic                     done;
    logic [WIDTH*WORDS-1:0]   sum_out;
    logic                     cout;

`ifdef SUB_MODE_EN
    modport master (output start, a_in, b_in, sub, input busy, done, sum_out, cout);
    modport slave  (input start, a_in, b_in, sub, output busy, done, sum_out, cout);
`else
    modport master (output start, a_in, b_in, input busy, done, sum_out, cout);
    modport slave  (input start, a_in, b_in, output busy, done, sum_out, cout);
`endif

endinterface

// File: rtl/nbit_ripple_adder.sv
// Plain WIDTH-bit ripple-carry adder; the slow shared datapath.
module nbit_ripple_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[WIDTH];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Runs one WIDTH-bit ripple adder over WORDS operand words, LS word first, with a settle wait per word.
// Define SUB_MODE_EN to add the sub input (A-B via ~B and carry-in 1).
module multiword_add_sequencer
    import add_seq_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned WORDS         = 4,
    parameter int unsigned SETTLE_CYCLES = 42
) (
    input  logic       clk,
    input  logic       rst,
    add_seq_if.slave   bus
);

    localparam int unsigned TOT = WIDTH * WORDS;
    localparam int unsigned IW  = bits_for(WORDS);
    localparam int unsigned CW  = bits_for(SETTLE_CYCLES + 1);

    localparam logic [IW-1:0] LAST_IDX   = IW'(WORDS - 1);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(SETTLE_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [TOT-1:0]   a_q;
    logic [TOT-1:0]   b_q;
`ifdef SUB_MODE_EN
    logic             sub_q;
`endif
    logic [IW-1:0]    idx;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [TOT-1:0]   work;
    logic [TOT-1:0]   work_nxt;
    logic [TOT-1:0]   sum_q;
    logic             cout_q;

    logic [WIDTH-1:0] a_word;
    logic [WIDTH-1:0] b_word;
    logic [WIDTH-1:0] b_fed;
    logic [WIDTH-1:0] add_s;
    logic             add_co;

    // Word select from latched operands, and the work image with the current word replaced.
    always_comb begin
        a_word   = '0;
        b_word   = '0;
        work_nxt = work;
        for (int unsigned w = 0; w < WORDS; w++) begin
            if (idx == IW'(w)) begin
                a_word                     = a_q[w*WIDTH +: WIDTH];
                b_word                     = b_q[w*WIDTH +: WIDTH];
                work_nxt[w*WIDTH +: WIDTH] = add_s;
            end
        end
    end

`ifdef SUB_MODE_EN
    assign b_fed = sub_q ? ~b_word : b_word;
`else
    assign b_fed = b_word;
`endif

    nbit_ripple_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a   (a_word),
        .b   (b_fed),
        .cin (carry),
        .s   (add_s),
        .co  (add_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SETTLE;
            SETTLE:  if (cnt == '0) state_nxt = CAPTURE;
            CAPTURE: state_nxt = (idx == LAST_IDX) ? DONE : SETTLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
`ifdef SUB_MODE_EN
            sub_q  <= 1'b0;
`endif
            idx    <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            work   <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q   <= bus.a_in;
                        b_q   <= bus.b_in;
                        idx   <= '0;
                        cnt   <= CNT_RELOAD;
`ifdef SUB_MODE_EN
                        sub_q <= bus.sub;
                        carry <= bus.sub;
`else
                        carry <= 1'b0;
`endif
                    end
                end
                SETTLE: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                CAPTURE: begin
                    work  <= work_nxt;
                    carry <= add_co;
                    // Result registers load on the same edge that enters DONE, so they take
                    // the merged image rather than work, which is only updated on this edge.
                    if (idx == LAST_IDX) begin
                        sum_q  <= work_nxt;
                        cout_q <= add_co;
                    end else begin
                        idx <= idx + 1'b1;
                        cnt <= CNT_RELOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
    assign bus.sum_out = sum_q;
    assign bus.cout    = cout_q;

endmodule
